// File: rtl/pc_fetch_sequencer_if.sv
// Signal bundle between pc_fetch_sequencer, instruction memory and the decoder.
// The master modport is the sequencer side; slave is the memory/decoder side.
interface pc_fetch_sequencer_if;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic        jmp_valid;
    logic [15:0] jmp_target;
    logic        br_valid;
    logic        br_taken;
    logic [11:0] br_offset;
    logic        halt;
    logic        halted;
    logic [15:0] pc;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_data,
        output instr_valid,
        output instr,
        input  instr_ready,
        input  jmp_valid,
        input  jmp_target,
        input  br_valid,
        input  br_taken,
        input  br_offset,
        input  halt,
        output halted,
        output pc
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_data,
        input  instr_valid,
        input  instr,
        output instr_ready,
        output jmp_valid,
        output jmp_target,
        output br_valid,
        output br_taken,
        output br_offset,
        output halt,
        input  halted,
        input  pc
    );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// Program counter and single-outstanding instruction fetch controller for the 16-bit lab CPU.
// Fetches one word per req/ack handshake and hands it to the decoder over valid/ready.
module pc_fetch_sequencer #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic                 clk,
    input  logic                 rst,
    pc_fetch_sequencer_if.master bus
);

    localparam logic [1:0] ST_REQ  = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    logic [1:0]  r_state;
    logic [15:0] r_pc;
    logic        r_imem_req;
    logic        r_instr_valid;
    logic [15:0] r_instr;
    logic        r_halted;

    logic        w_ack_taken;
    logic        w_accept;
    logic [15:0] w_br_offset_ext;
    logic [15:0] w_pc_inc;
    logic [15:0] w_next_pc;

    // An ack only counts while a request is actually being driven.
    assign w_ack_taken     = (r_state == ST_REQ) && r_imem_req && bus.imem_ack;
    assign w_accept        = (r_state == ST_HOLD) && r_instr_valid && bus.instr_ready;
    assign w_br_offset_ext = {{4{bus.br_offset[11]}}, bus.br_offset};
    assign w_pc_inc        = r_pc + 16'd1;

    // NOTE: w_next_pc gets a default before any branch so no path leaves it unassigned (no latch).
    always_comb begin
        w_next_pc = w_pc_inc;
        if (bus.jmp_valid) begin
            w_next_pc = bus.jmp_target;
        end else if (bus.br_valid && bus.br_taken) begin
            w_next_pc = w_pc_inc + w_br_offset_ext;
        end
    end

    // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_REQ;
            r_pc          <= RESET_PC;
            r_imem_req    <= 1'b0;
            r_instr_valid <= 1'b0;
            r_instr       <= 16'h0000;
            r_halted      <= 1'b0;
        end else begin
            case (r_state)
                ST_REQ: begin
                    if (!r_imem_req) begin
                        r_imem_req <= 1'b1;
                    end else if (w_ack_taken) begin
                        r_instr       <= bus.imem_data;
                        r_instr_valid <= 1'b1;
                        r_imem_req    <= 1'b0;
                        r_state       <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (w_accept) begin
                        r_pc          <= w_next_pc;
                        r_instr_valid <= 1'b0;
                        if (bus.halt) begin
                            r_state  <= ST_HALT;
                            r_halted <= 1'b1;
                        end else begin
                            // Request goes out the cycle after accept, no idle gap.
                            r_state    <= ST_REQ;
                            r_imem_req <= 1'b1;
                        end
                    end
                end
                ST_HALT: begin
                    r_imem_req    <= 1'b0;
                    r_instr_valid <= 1'b0;
                    r_halted      <= 1'b1;
                end
                default: begin
                    r_state       <= ST_REQ;
                    r_imem_req    <= 1'b0;
                    r_instr_valid <= 1'b0;
                    r_halted      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.imem_req    = r_imem_req;
    assign bus.imem_addr   = r_pc;
    assign bus.instr_valid = r_instr_valid;
    assign bus.instr       = r_instr;
    assign bus.halted      = r_halted;
    assign bus.pc          = r_pc;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Scoreboard bench for pc_fetch_sequencer: stimulus queues expected fetch addresses and
// instruction words, a monitor pops and compares them on every ack and every accept.
module tb_pc_fetch_sequencer;

    logic clk;
    logic rst;

    pc_fetch_sequencer_if dut_if ();

    pc_fetch_sequencer #(.RESET_PC(16'h0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dut_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] q_addr[$];
    logic [15:0] q_instr[$];

    int mem_delay  = 0;
    bit ack_toggle = 1'b0;

    function automatic logic [15:0] mem_word(input logic [15:0] addr);
        return addr ^ 16'hC3A5;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_fetch(input logic [15:0] addr);
        q_addr.push_back(addr);
        q_instr.push_back(mem_word(addr));
    endtask

    // Memory model: acks after mem_delay cycles of request; ack_toggle mode wiggles ack blindly.
    initial begin
        int wait_cnt;
        wait_cnt          = 0;
        dut_if.imem_ack   = 1'b0;
        dut_if.imem_data  = 16'h0000;
        forever begin
            @(posedge clk);
            #2;
            if (ack_toggle) begin
                dut_if.imem_ack  = ~dut_if.imem_ack;
                dut_if.imem_data = 16'hDEAD;
            end else if (dut_if.imem_req === 1'b1 && wait_cnt >= mem_delay) begin
                dut_if.imem_ack  = 1'b1;
                dut_if.imem_data = mem_word(dut_if.imem_addr);
                wait_cnt         = 0;
            end else begin
                dut_if.imem_ack = 1'b0;
                wait_cnt        = (dut_if.imem_req === 1'b1) ? wait_cnt + 1 : 0;
            end
        end
    end

    // Monitor: compares every completed fetch and every accepted instruction.
    initial begin
        forever begin
            @(negedge clk);
            if (dut_if.imem_req === 1'b1 && dut_if.imem_ack === 1'b1) begin
                if (q_addr.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_fetch: got addr %h expected none at %0t", dut_if.imem_addr, $time);
                end else begin
                    check("fetch_addr", dut_if.imem_addr, q_addr.pop_front());
                end
            end
            if (dut_if.instr_valid === 1'b1 && dut_if.instr_ready === 1'b1) begin
                if (q_instr.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_accept: got instr %h expected none at %0t", dut_if.instr, $time);
                end else begin
                    check("accept_instr", dut_if.instr, q_instr.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Waits for instr_valid, holds ready low for extra_wait cycles, then accepts once.
    task automatic accept(input int extra_wait, input logic jv, input logic [15:0] jt,
                          input logic bv, input logic bt, input logic [11:0] bo, input logic h);
        int          n;
        logic [15:0] held;
        n = 0;
        @(negedge clk);
        while (dut_if.instr_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait", 16'(dut_if.instr_valid), 16'd1);
        held = dut_if.instr;
        repeat (extra_wait) begin
            @(negedge clk);
            check("hold_instr", dut_if.instr, held);
            check("hold_valid", 16'(dut_if.instr_valid), 16'd1);
        end
        @(posedge clk);
        #1;
        dut_if.instr_ready = 1'b1;
        dut_if.jmp_valid   = jv;
        dut_if.jmp_target  = jt;
        dut_if.br_valid    = bv;
        dut_if.br_taken    = bt;
        dut_if.br_offset   = bo;
        dut_if.halt        = h;
        @(posedge clk);
        #1;
        dut_if.instr_ready = 1'b0;
        dut_if.jmp_valid   = 1'b0;
        dut_if.br_valid    = 1'b0;
        dut_if.br_taken    = 1'b0;
        dut_if.halt        = 1'b0;
    endtask

    initial begin
        logic [5:0] req_pattern;
        logic [5:0] valid_pattern;
        req_pattern   = 6'b101010;
        valid_pattern = 6'b010100;

        rst                = 1'b1;
        dut_if.instr_ready = 1'b0;
        dut_if.jmp_valid   = 1'b0;
        dut_if.jmp_target  = 16'h0000;
        dut_if.br_valid    = 1'b0;
        dut_if.br_taken    = 1'b0;
        dut_if.br_offset   = 12'h000;
        dut_if.halt        = 1'b0;

        // Sequential fetch, same-cycle ack, ready held high; jump to 0x0100 on the third word.
        expect_fetch(16'h0000);
        expect_fetch(16'h0001);
        expect_fetch(16'h0002);
        expect_fetch(16'h0100);
        repeat (2) @(posedge clk);
        #1;
        rst                = 1'b0;
        dut_if.instr_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0) begin
                check("reset_pc", dut_if.pc, 16'h0000);
                check("reset_instr", dut_if.instr, 16'h0000);
            end
            check("seq_req", 16'(dut_if.imem_req), 16'(req_pattern[i]));
            check("seq_valid", 16'(dut_if.instr_valid), 16'(valid_pattern[i]));
            check("seq_halted", 16'(dut_if.halted), 16'd0);
        end
        @(posedge clk);
        #1;
        dut_if.jmp_valid  = 1'b1;
        dut_if.jmp_target = 16'h0100;
        @(posedge clk);
        #1;
        dut_if.instr_ready = 1'b0;
        dut_if.jmp_valid   = 1'b0;

        // Taken branches at both offset extremes.
        expect_fetch(16'h0900);
        accept(0, 1'b0, 16'h0000, 1'b1, 1'b1, 12'h7FF, 1'b0);
        expect_fetch(16'h0010);
        accept(0, 1'b1, 16'h0010, 1'b0, 1'b0, 12'h000, 1'b0);
        expect_fetch(16'hF811);
        accept(0, 1'b0, 16'h0000, 1'b1, 1'b1, 12'h800, 1'b0);

        // Jump beats a taken branch.
        expect_fetch(16'h1234);
        accept(0, 1'b1, 16'h1234, 1'b1, 1'b1, 12'h005, 1'b0);

        // Jump to 0x0005, then stall that fetch for three cycles.
        expect_fetch(16'h0005);
        accept(0, 1'b1, 16'h0005, 1'b0, 1'b0, 12'h000, 1'b0);
        mem_delay = 3;
        repeat (3) begin
            @(negedge clk);
            check("stall_req", 16'(dut_if.imem_req), 16'd1);
            check("stall_addr", dut_if.imem_addr, 16'h0005);
            check("stall_valid", 16'(dut_if.instr_valid), 16'd0);
        end
        mem_delay = 0;

        // Not-taken branch is sequential.
        expect_fetch(16'h0006);
        accept(0, 1'b0, 16'h0000, 1'b1, 1'b0, 12'h7FF, 1'b0);

        // Ready held off for four cycles; then wrap from 0xFFFF.
        expect_fetch(16'hFFFF);
        accept(4, 1'b1, 16'hFFFF, 1'b0, 1'b0, 12'h000, 1'b0);
        expect_fetch(16'h0000);
        accept(0, 1'b0, 16'h0000, 1'b0, 1'b0, 12'h000, 1'b0);

        // Halt at 0x0007; acks toggled while halted must not start a fetch.
        expect_fetch(16'h0007);
        accept(0, 1'b1, 16'h0007, 1'b0, 1'b0, 12'h000, 1'b0);
        accept(0, 1'b0, 16'h0000, 1'b0, 1'b0, 12'h000, 1'b1);
        ack_toggle = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check("halt_halted", 16'(dut_if.halted), 16'd1);
            check("halt_req", 16'(dut_if.imem_req), 16'd0);
            check("halt_valid", 16'(dut_if.instr_valid), 16'd0);
            check("halt_pc", dut_if.pc, 16'h0008);
        end
        ack_toggle = 1'b0;

        // Reset out of HALT, then reset again while a slow fetch is pending.
        mem_delay = 10;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_halted", 16'(dut_if.halted), 16'd0);
        repeat (2) @(negedge clk);
        check("pending_req", 16'(dut_if.imem_req), 16'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_req", 16'(dut_if.imem_req), 16'd0);
        check("midrst_pc", dut_if.pc, 16'h0000);
        check("midrst_valid", 16'(dut_if.instr_valid), 16'd0);
        mem_delay = 0;
        expect_fetch(16'h0000);
        accept(0, 1'b0, 16'h0000, 1'b0, 1'b0, 12'h000, 1'b1);

        repeat (4) @(negedge clk);
        check("drain_addr_q", 16'(q_addr.size()), 16'd0);
        check("drain_instr_q", 16'(q_instr.size()), 16'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
- Program-counter and instruction-fetch controller for the 16-bit lab CPU.
- Issues word-addressed fetch requests to instruction memory using a req/ack handshake.
- Presents each fetched word to the decoder using a valid/ready handshake.
- Picks the next PC: sequential, absolute jump, or PC-relative branch. The branch offset is a 12-bit immediate sign-extended to 16 bits inside this block.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  16  fetch address; equals pc.
- imem_ack  input  1  memory has put valid data on imem_data this cycle.
- imem_data  input  16  fetched instruction word.
- instr_valid  output  1  instr holds an instruction not yet accepted.
- instr  output  16  registered instruction word.
- instr_ready  input  1  decoder accepts instr this cycle.
- jmp_valid  input  1  absolute jump; qualified only on accept.
- jmp_target  input  16  jump destination.
- br_valid  input  1  conditional branch resolved; qualified only on accept.
- br_taken  input  1  branch outcome.
- br_offset  input  12  signed word offset, two's complement.
- halt  input  1  stop fetching after this instruction; qualified only on accept.
- halted  output  1  sequencer is in HALT.
- pc  output  16  address of the current or pending instruction.

Behaviour:
- Reset (rst=1 at an edge, regardless of state), all values visible the next cycle:
  - pc=RESET_PC, state=REQ.
  - imem_req=0, instr_valid=0, instr=16'h0000, halted=0.
  - Any outstanding ack is abandoned.
- States: REQ, HOLD, HALT. Outputs are registered.
- REQ:
  - imem_req=1 from the first cycle after entry; imem_addr=pc held stable until ack.
  - On imem_ack=1: instr<=imem_data, instr_valid<=1, imem_req<=0, go to HOLD.
  - An ack in the same cycle the request is first driven is legal. Minimum fetch latency is one cycle from req to instr_valid.
- Ack outside REQ (imem_req=0) is ignored.
- HOLD:
  - instr and instr_valid stay stable until accept (instr_valid && instr_ready).
  - Redirect/halt inputs are don't-care in cycles without accept.
- On accept, in priority order:
  1. jmp_valid=1 → next_pc=jmp_target.
  2. else br_valid && br_taken → next_pc = pc + 1 + {{4{br_offset[11]}}, br_offset}.
  3. else → next_pc = pc + 1.
  - All arithmetic is modulo 2^16 (wrap, no flag).
  - pc<=next_pc and instr_valid<=0.
  - If halt=1: go to HALT. pc still updates, imem_req stays 0.
  - Otherwise: go to REQ. imem_req=1 and imem_addr=next_pc in the cycle after accept.
- Simultaneous jmp_valid and taken branch: jump wins.
- br_valid=1 with br_taken=0: sequential.
- HALT: halted=1, imem_req=0, instr_valid=0. Held until rst; no other input leaves HALT.
- Throughput: at most one instruction per 2 cycles (ack cycle, accept cycle). No prefetch; only one outstanding request.
- instr_ready while instr_valid=0 has no effect.

Test Plan:
- Reset and sequential fetch: rst pulse; memory acks in the same cycle as the request; ready is held high. Required:
  - imem_addr sequence 0000, 0001, 0002.
  - instr_valid pulses every 2 cycles.
  - halted=0.
- Taken branches, both offset extremes:
  - pc=0x0100, br_offset=12'h7FF, taken, on accept → next imem_addr=0x0900.
  - pc=0x0010, br_offset=12'h800 → 0xF811.
- Jump priority and not-taken branch:
  - jmp_valid=1, jmp_target=0x1234, and a taken branch in the same accept → 0x1234.
  - br_valid=1, br_taken=0 at pc=0x0005 → 0x0006.
- Handshake stalls and wrap:
  - ack delayed 3 cycles → imem_req and imem_addr stay stable.
  - ready delayed 4 cycles → instr stable.
  - pc=0xFFFF sequential → 0x0000.
- Halt and reset mid-operation:
  - halt=1 on accept at pc=0x0007 → halted=1, pc=0x0008, no further imem_req even if ack is toggled.
  - rst during REQ with ack pending → next cycle imem_req=0, pc=RESET_PC, then a fresh fetch of RESET_PC.
